// File: rtl/sigdelt_sample_ctrl.sv
// -----------------------------------------------------------------------------
// sigdelt_sample_ctrl
//
// Sample-rate controller in front of a first-order sigma-delta modulator.
// Each sample is held on the modulator input for (sdc_osr + 1) clocks. When
// the run request is withdrawn, the modulator input is walked back to
// midscale (50% output density) in RAMP_STEP increments, one per hold
// period, before the block goes idle. This keeps the analogue output from
// stepping abruptly when the stream stops.
//
// Parameters
//   DATA_W     width of the sample word and of the modulator input
//   OSR_W      width of the hold counter and of sdc_osr
//   RAMP_STEP  per-period step applied while ramping to midscale
//
// Ports
//   sdc_clk    in   1        single clock, shared with the modulator
//   sdc_rst_n  in   1        synchronous active-low reset
//   sdc_en     in   1        run request
//   sdc_osr    in   OSR_W    clocks per sample minus 1
//   s_din      in   DATA_W   unsigned offset-binary sample
//   s_valid    in   1        sample present
//   s_ready    out  1        sample accepted this cycle (combinational)
//   mod_din    out  DATA_W   registered word to the modulator input
//   underrun   out  1        registered 1-cycle pulse: a sample was missed
//   busy       out  1        block is running or ramping
// -----------------------------------------------------------------------------
module sigdelt_sample_ctrl #(
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       OSR_W     = 8,
    parameter logic [DATA_W-1:0] RAMP_STEP = 16'h1000
) (
    input  logic              sdc_clk,
    input  logic              sdc_rst_n,
    input  logic              sdc_en,
    input  logic [OSR_W-1:0]  sdc_osr,
    input  logic [DATA_W-1:0] s_din,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] mod_din,
    output logic              underrun,
    output logic              busy
);

    // Midscale: the code at which the modulator emits a 50% density stream.
    localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [OSR_W-1:0]  CNT_ONE = OSR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [OSR_W-1:0]    cnt_q,      cnt_d;
    logic [DATA_W-1:0]   mod_din_q,  mod_din_d;
    logic                underrun_q, underrun_d;

    // -------------------------------------------------------------------------
    // Period timing
    // -------------------------------------------------------------------------
    // A boundary is the last cycle of a hold period. IDLE keeps cnt at zero,
    // so the first RUN cycle after leaving IDLE is always a boundary.
    logic             boundary;
    logic [OSR_W-1:0] cnt_next;

    always_comb begin
        boundary = (state_q != ST_IDLE) && (cnt_q == '0);
        // sdc_osr is sampled only here, so a new value never shortens or
        // stretches a period that has already started.
        cnt_next = boundary ? sdc_osr : (cnt_q - CNT_ONE);
    end

    // -------------------------------------------------------------------------
    // Ramp-to-midscale arithmetic
    // -------------------------------------------------------------------------
    // The distance to MID is compared against the step one bit wider than the
    // data, so neither direction can wrap. Once the distance exceeds the step,
    // the plain DATA_W add/subtract is known to stay between the current value
    // and MID.
    logic              above_mid;
    logic [DATA_W:0]   dist_ext;
    logic [DATA_W-1:0] ramp_val;

    always_comb begin
        above_mid = (mod_din_q > MID);
        if (above_mid) begin
            dist_ext = {1'b0, mod_din_q} - {1'b0, MID};
        end else begin
            dist_ext = {1'b0, MID} - {1'b0, mod_din_q};
        end

        if (dist_ext <= {1'b0, RAMP_STEP}) begin
            ramp_val = MID;
        end else if (above_mid) begin
            ramp_val = mod_din_q - RAMP_STEP;
        end else begin
            ramp_val = mod_din_q + RAMP_STEP;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default at the top so that no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mod_din_d  = mod_din_q;
        underrun_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                mod_din_d = MID;
                if (sdc_en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = cnt_next;
                if (!sdc_en) begin
                    // Leaving: no transfer and no underrun, the count
                    // carries on into the ramp.
                    state_d = ST_RAMP;
                end else if (boundary) begin
                    if (s_valid) begin
                        mod_din_d = s_din;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end

            ST_RAMP: begin
                if (sdc_en) begin
                    // Abort the ramp; restarting with cnt at zero makes the
                    // first RUN cycle a boundary so a sample can be taken
                    // immediately from the current level.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (boundary) begin
                    if (mod_din_q == MID) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        mod_din_d = ramp_val;
                        cnt_d     = cnt_next;
                    end
                end else begin
                    cnt_d = cnt_next;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                mod_din_d = MID;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge, not in the sensitivity list,
    // so it is a plain data-path priority term and overrides everything else.
    always_ff @(posedge sdc_clk) begin
        if (!sdc_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mod_din_q  <= MID;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mod_din_q  <= mod_din_d;
            underrun_q <= underrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        s_ready  = (state_q == ST_RUN) && (cnt_q == '0) && sdc_en;
        mod_din  = mod_din_q;
        underrun = underrun_q;
        busy     = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_sigdelt_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sigdelt_sample_ctrl
//
// Directed scenarios (reset, hold, underrun, full rate, ramp, re-enable)
// followed by a randomized phase. Every cycle the outputs are compared
// against a behavioural model that tracks the mode, the cycles left in the
// current hold period and the output level as plain integers.
// -----------------------------------------------------------------------------
module tb_sigdelt_sample_ctrl;

    localparam int DW   = 16;
    localparam int OW   = 8;
    localparam int MID  = 32768;
    localparam int STEP = 4096;

    logic          sdc_clk = 1'b0;
    logic          sdc_rst_n;
    logic          sdc_en;
    logic [OW-1:0] sdc_osr;
    logic [DW-1:0] s_din;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] mod_din;
    logic          underrun;
    logic          busy;

    sigdelt_sample_ctrl #(
        .DATA_W    (DW),
        .OSR_W     (OW),
        .RAMP_STEP (16'h1000)
    ) dut (
        .sdc_clk   (sdc_clk),
        .sdc_rst_n (sdc_rst_n),
        .sdc_en    (sdc_en),
        .sdc_osr   (sdc_osr),
        .s_din     (s_din),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .mod_din   (mod_din),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 sdc_clk = ~sdc_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_RAMP} mode_t;
    mode_t m_mode = M_IDLE;
    int    m_left = 0;      // cycles remaining in the current hold period
    int    m_out  = MID;    // level on the modulator input
    bit    m_under = 1'b0;

    function automatic int toward_mid(input int v);
        if (v > MID) return (v - STEP > MID) ? v - STEP : MID;
        if (v < MID) return (v + STEP < MID) ? v + STEP : MID;
        return MID;
    endfunction

    task automatic model_step();
        bit bnd;
        bnd     = (m_mode != M_IDLE) && (m_left == 0);
        m_under = 1'b0;
        if (!sdc_rst_n) begin
            m_mode = M_IDLE;
            m_left = 0;
            m_out  = MID;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_left = 0;
                    m_out  = MID;
                    if (sdc_en) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (sdc_en && bnd) begin
                        if (s_valid) m_out = int'(s_din);
                        else         m_under = 1'b1;
                    end
                    m_left = bnd ? int'(sdc_osr) : m_left - 1;
                    if (!sdc_en) m_mode = M_RAMP;
                end
                default: begin
                    if (sdc_en) begin
                        m_mode = M_RUN;
                        m_left = 0;
                    end else if (bnd) begin
                        if (m_out == MID) begin
                            m_mode = M_IDLE;
                            m_left = 0;
                        end else begin
                            m_out  = toward_mid(m_out);
                            m_left = int'(sdc_osr);
                        end
                    end else begin
                        m_left = m_left - 1;
                    end
                end
            endcase
        end
    endtask

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare all outputs at the falling edge, then advance DUT and model.
    task automatic tick();
        @(negedge sdc_clk);
        check("s_ready",  32'(s_ready),  32'(m_mode == M_RUN && m_left == 0 && sdc_en));
        check("busy",     32'(busy),     32'(m_mode != M_IDLE));
        check("mod_din",  32'(mod_din),  32'(m_out));
        check("underrun", 32'(underrun), 32'(m_under));
        @(posedge sdc_clk);
        model_step();
        #1;
    endtask

    // Advance until the model says the next RUN cycle is a boundary.
    task automatic wait_boundary();
        for (int i = 0; i < 64; i++) begin
            if (m_mode == M_RUN && m_left == 0) return;
            tick();
        end
        n_cmp++;
        n_fail++;
        $error("FAIL wait_boundary: observed no boundary expected one within 64 cycles");
    endtask

    logic [DW-1:0] ramp_seq [3];
    logic [DW-1:0] pat;

    initial begin
        ramp_seq = '{16'h9800, 16'h8800, 16'h8000};

        sdc_rst_n = 1'b0;
        sdc_en    = 1'b0;
        s_valid   = 1'b0;
        sdc_osr   = '0;
        s_din     = '0;
        @(posedge sdc_clk);
        model_step();
        #1;
        tick();
        check("rst_mod_din", 32'(mod_din), 32'h8000);
        check("rst_busy",    32'(busy),    32'h0);

        // ---- Hold: osr=3, sample held for 4 cycles -----------------------
        sdc_rst_n = 1'b1;
        sdc_osr   = 8'd3;
        sdc_en    = 1'b1;
        s_valid   = 1'b1;
        s_din     = 16'h1234;
        tick();
        check("hold_first_ready", 32'(s_ready), 32'h1);
        tick();
        s_din = 16'h4000;
        for (int i = 0; i < 4; i++) begin
            check("hold_mod_din", 32'(mod_din), 32'h1234);
            check("hold_ready",   32'(s_ready), 32'(i == 3));
            tick();
        end
        check("hold_next", 32'(mod_din), 32'h4000);

        // ---- Underrun: osr=1, one boundary without a sample ---------------
        sdc_osr = 8'd1;
        wait_boundary();
        s_valid = 1'b0;
        check("ur_ready", 32'(s_ready), 32'h1);
        tick();
        check("ur_pulse",   32'(underrun), 32'h1);
        check("ur_mod_din", 32'(mod_din),  32'h4000);
        s_valid = 1'b1;
        s_din   = 16'h5555;
        check("ur_mid_ready", 32'(s_ready), 32'h0);
        tick();
        check("ur_clear",      32'(underrun), 32'h0);
        check("ur_next_ready", 32'(s_ready),  32'h1);
        tick();
        check("ur_recover", 32'(mod_din), 32'h5555);

        // ---- Full rate: osr=0, incrementing pattern -----------------------
        sdc_osr = 8'd0;
        wait_boundary();
        for (int k = 0; k < 8; k++) begin
            pat   = 16'h0100 + 16'(k);
            s_din = pat;
            check("fr_ready", 32'(s_ready), 32'h1);
            tick();
            check("fr_mod_din", 32'(mod_din), 32'(pat));
        end

        // ---- Ramp down from above midscale --------------------------------
        s_din = 16'hA800;
        tick();
        check("rd_load", 32'(mod_din), 32'hA800);
        sdc_en  = 1'b0;
        s_valid = 1'b0;
        tick();
        check("rd_enter_busy", 32'(busy),    32'h1);
        check("rd_enter_hold", 32'(mod_din), 32'hA800);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_step", 32'(mod_din), 32'(ramp_seq[i]));
        end
        tick();
        check("rd_idle_busy", 32'(busy),    32'h0);
        check("rd_idle_mid",  32'(mod_din), 32'h8000);

        // ---- Ramp up from below midscale, clamped -------------------------
        sdc_en = 1'b1;
        tick();
        s_valid = 1'b1;
        s_din   = 16'h7800;
        tick();
        check("ru_load", 32'(mod_din), 32'h7800);
        sdc_en  = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        check("ru_clamp", 32'(mod_din), 32'h8000);
        tick();
        check("ru_idle_busy", 32'(busy), 32'h0);

        // ---- Re-enable mid-ramp ------------------------------------------
        sdc_en = 1'b1;
        tick();
        s_valid = 1'b1;
        s_din   = 16'hA800;
        tick();
        sdc_en  = 1'b0;
        s_valid = 1'b0;
        tick();
        tick();
        check("re_ramp_level", 32'(mod_din), 32'h9800);
        sdc_en = 1'b1;
        tick();
        check("re_busy",    32'(busy),    32'h1);
        check("re_ready",   32'(s_ready), 32'h1);
        check("re_mod_din", 32'(mod_din), 32'h9800);
        tick();
        check("re_hold", 32'(mod_din), 32'h9800);
        s_valid = 1'b1;
        s_din   = 16'h1111;
        tick();
        check("re_first_xfer", 32'(mod_din), 32'h1111);

        // ---- Reset while running -----------------------------------------
        s_din = 16'h1234;
        tick();
        check("rr_pre", 32'(mod_din), 32'h1234);
        sdc_rst_n = 1'b0;
        tick();
        check("rr_mod_din",  32'(mod_din),  32'h8000);
        check("rr_ready",    32'(s_ready),  32'h0);
        check("rr_busy",     32'(busy),     32'h0);
        check("rr_underrun", 32'(underrun), 32'h0);
        sdc_rst_n = 1'b1;

        // ---- Randomized phase --------------------------------------------
        for (int c = 0; c < 3000; c++) begin
            sdc_rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) sdc_en = ~sdc_en;
            s_valid = ($urandom_range(0, 3) != 0);
            s_din   = 16'($urandom);
            if ($urandom_range(0, 49) == 0) sdc_osr = 8'($urandom_range(0, 4));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
